// File: rtl/sixbitasin.sv
// Six-bit arcsine: scans candidates x = 0..63, one per clock, through a sixbitsin
// evaluator and reports the smallest x whose approximation matches the target.

module sixbitsin (
  input  logic [5:0] x,
  output logic [5:0] y,
  output logic       overflow
);
  logic [17:0] cube;
  logic        cube_ovf;
  logic [5:0]  quot;
  logic [6:0]  diff;

  always_comb begin
    cube     = {12'd0, x} * {12'd0, x} * {12'd0, x};
    cube_ovf = |cube[17:6];
    // An overflowed cube contributes nothing; only the flag survives.
    quot     = cube_ovf ? 6'd0 : (cube[5:0] / 6'd6);
    diff     = {1'b0, x} - {1'b0, quot};
    y        = diff[5:0];
    overflow = cube_ovf | diff[6];
  end
endmodule

module sixbitasin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] yin,
  input  logic       strict,
  output logic       busy,
  output logic       done,
  output logic [5:0] xout,
  output logic       found,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t     state, state_d;
  logic [5:0] y_q;
  logic       strict_q;
  logic [5:0] cnt;
  logic [5:0] cand_y;
  logic       cand_ovf;
  logic       hit;
  logic       load, adv, wr;

  sixbitsin u_sin (
    .x        (cnt),
    .y        (cand_y),
    .overflow (cand_ovf)
  );

  assign hit  = (cand_y == y_q) && (!strict_q || !cand_ovf);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    adv     = 1'b0;
    wr      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SEARCH;
          load    = 1'b1;
        end
      end
      SEARCH: begin
        // Terminal check precedes the increment, so cnt never wraps.
        if (hit || (cnt == 6'd63)) begin
          state_d = DONE;
          wr      = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      xout     <= 6'd0;
      found    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      if (load)
        cnt <= 6'd0;
      else if (adv)
        cnt <= cnt + 6'd1;
      if (wr) begin
        xout     <= hit ? cnt : 6'd0;
        found    <= hit;
        overflow <= hit & cand_ovf;
      end
    end
  end

  // Operands are captured once per request; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      y_q      <= yin;
      strict_q <= strict;
    end
  end
endmodule

// File: doc/sixbitasin.md
# sixbitasin

Inverse of the six-bit sine approximation: given a target value `yin`, finds the smallest six-bit `x` whose sine approximation `x - floor(x^3/6)` equals `yin`. It scans candidates sequentially, one per clock, through a single internal `sixbitsin` instance. It sits beside `sixbitsin` in the calculator datapath and uses a start/busy/done handshake so the control FSM can request an arcsine and wait for it.

## Interface
- No parameters; the width is fixed at 6 bits, matching the rest of the sixbit family.
- `clk`  input  1  single clock; everything is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request pulse; sampled only in IDLE.
- `yin`  input  6  target sine value; captured when `start` is accepted.
- `strict`  input  1  captured with `start`; 1 = skip candidates whose `sixbitsin` overflow flag is set.
- `busy`  output  1  high in SEARCH and DONE.
- `done`  output  1  one-cycle pulse when a result is valid.
- `xout`  output  6  matching candidate; 0 if none found.
- `found`  output  1  1 = match found.
- `overflow`  output  1  `sixbitsin` overflow flag of the matching candidate; 0 if none found.

## Operation
- Internal registers: `y_q`[5:0], `strict_q`, candidate counter `cnt`[5:0], and state.
- States are IDLE, SEARCH and DONE.
- The candidate function is evaluated exactly as `sixbitsin` produces it (6-bit wrap, no widening):
  - `f(0)=0`, `f(1)=1`, `f(2)=1`.
  - `f(3)=63`, overflow=1 (subtract borrow).
  - `f(x)=x` for x≥4, overflow=1 (cube overflow; the quotient is forced to 0).
- Candidate k is a hit when `f(k)==y_q`, and either `strict_q==0` or the overflow flag of k is 0.
- IDLE:
  - `start=1`: latch `yin`→`y_q` and `strict`→`strict_q`, set `cnt`=0, go to SEARCH.
  - Otherwise stay in IDLE.
- SEARCH, evaluating `cnt` combinationally:
  - Hit: `xout`←`cnt`, `found`←1, `overflow`←flag(`cnt`), go to DONE.
  - No hit and `cnt==63`: `xout`←0, `found`←0, `overflow`←0, go to DONE.
  - Otherwise `cnt`←`cnt+1`.
- DONE: `done`=1 for exactly this cycle, then return to IDLE.
- `xout`, `found` and `overflow` hold their value until the next search writes a result.
- The smallest matching x always wins; the scan is strictly ascending.
- `start` in SEARCH or DONE is ignored; it is not queued.
- A change on `yin` or `strict` after acceptance has no effect on the running search.
- Counter wrap: `cnt` never increments past 63; the terminal check happens before the increment.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `xout`=0, `found`=0, `overflow`=0, `cnt`=0.
- Let edge E be the edge that samples `start`.
- Candidate k is evaluated in the cycle after edge E+k.
- A hit at k registers at edge E+k+1.
- `done` and `busy` are high in the cycle after edge E+k+1; results are valid in that same cycle.
- Latency from `start` to `done`:
  - k+2 cycles for a hit at k, so minimum 2 (y=0).
  - 65 cycles for a miss.
- `busy` rises the cycle after edge E and falls with the cycle after `done`.
- Back-to-back: `start` may be asserted in the cycle following `done`, and is accepted at the next edge.
- `rst` mid-search:
  - Abort at the next edge to IDLE with all outputs at reset values.
  - No `done` pulse is issued.
  - The previous result is cleared.
- `rst` and `start` together: reset wins and the start is dropped.

## Test plan
- After reset: all outputs 0. Then `yin`=0, `strict`=0, `start` → `done` 2 cycles after start, `xout`=0, `found`=1, `overflow`=0.
- `yin`=1, `strict`=0 → `xout`=1 (not 2), `found`=1, `overflow`=0, latency 3. Then `yin`=63 → `xout`=3, `found`=1, `overflow`=1, latency 5.
- `yin`=5: with `strict`=0 → `xout`=5, `overflow`=1, latency 7. With `strict`=1 → `found`=0, `xout`=0, `overflow`=0, latency 65.
- `yin`=2, `strict`=0 (no preimage) → `found`=0 after 65 cycles. `busy` stays high throughout the scan; `done` is exactly one cycle wide.
- During a `yin`=40 search, pulse `start` with `yin`=1 at cycle 10 → ignored; the result is `xout`=40, `overflow`=1 at latency 42. A new `start` in the cycle after `done` is accepted.
- Assert `rst` at cycle 20 of a `yin`=50 search → IDLE next cycle, all outputs 0, no `done` pulse. A following `yin`=0 search completes normally.
